// File: rtl/gs232c_align_pkg.sv
// Shared definitions for the word alignment buffer.
//   cnt_t     : number of packets held (EMPTY / ONE / TWO)
//   PKT_WORDS : words per packet for the default N=2 configuration
//   pkt_words : words per packet for an arbitrary N
//   min_cnt   : clamp of an available-word count to the window width
package gs232c_align_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } cnt_t;

   localparam int unsigned N_DEF     = 2;
   localparam int unsigned PKT_WORDS = 1 << N_DEF;

   function automatic int unsigned pkt_words(input int unsigned n);
      return 32'(1) << n;
   endfunction

   function automatic int unsigned min_cnt(input int unsigned avail, input int unsigned k);
      return (avail < k) ? avail : k;
   endfunction

endpackage

// File: rtl/gs232c_win_extract.sv
// Window extraction: selects K consecutive words starting at word ptr of a
// 2^(N+1)-word concatenation and zeroes every word at index >= cnt.
// Ports:
//   win_in : {ent1, ent0}, word j at [j*W +: W]
//   ptr    : starting word offset into ent0
//   cnt    : number of valid words in the window
//   win    : K-word window, word 0 at [0 +: W]
module gs232c_win_extract #(
   parameter int unsigned N  = 2,
   parameter int unsigned K  = 4,
   parameter int unsigned W  = 32,
   parameter int unsigned CW = $clog2(K + 1)
) (
   input  logic [(W << (N + 1))-1:0] win_in,
   input  logic [N-1:0]              ptr,
   input  logic [CW-1:0]             cnt,
   output logic [W*K-1:0]            win
);

   localparam int unsigned TW = W << (N + 1);

   logic [TW-1:0] stg [0:N];
   logic          unused_hi;

   assign stg[0] = win_in;

   // Log shifter: level s moves the data down by 2^s words when ptr[s] is set.
   for (genvar s = 0; s < N; s++) begin : g_lvl
      assign stg[s+1] = ptr[s] ? (stg[s] >> (W << s)) : stg[s];
   end

   // Words beyond the window are never presented.
   assign unused_hi = ^stg[N][TW-1:W*K];

   always_comb begin
      win = '0;
      for (int i = 0; i < int'(K); i++) begin
         if (i < int'(cnt)) win[i*W +: W] = stg[N][i*W +: W];
      end
   end

endmodule

// File: rtl/gs232c_word_align_buf.sv
// Two-entry fetch-packet alignment buffer. Holds up to two packets of 2^N
// words and presents a window of up to K words starting at any word offset,
// spanning into the second packet when needed.
//
//   state (cnt) | meaning
//   EMPTY       | no packet held, ptr is 0
//   ONE         | ent0 holds the head packet, ptr indexes into it
//   TWO         | ent0 head, ent1 next packet, window may span both
//
// Ports:
//   clock, reset        : clock, async active-high reset
//   flush               : synchronous clear, blocks acceptance
//   in_valid/in_ready   : packet handshake (in_ready depends on out_take)
//   in_data, in_start   : packet and first-word offset (used on empty only)
//   out_cnt, out_data   : window word count and zero-padded window
//   out_take            : words consumed this cycle (clamped to out_cnt)
module gs232c_word_align_buf
   import gs232c_align_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned K  = 4,
   parameter int unsigned W  = 32,
   parameter int unsigned CW = $clog2(K + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [(W<<N)-1:0] in_data,
   input  logic [N-1:0]      in_start,
   output logic [CW-1:0]     out_cnt,
   output logic [W*K-1:0]    out_data,
   input  logic [CW-1:0]     out_take
);

   localparam int unsigned PKT = pkt_words(N);
   localparam int unsigned PW  = W << N;
   localparam int unsigned AW  = N + 2;

   logic [PW-1:0] ent0;
   logic [PW-1:0] ent1;
   cnt_t          cnt;
   logic [N-1:0]  ptr;

   logic [AW-1:0] avail;
   logic [CW-1:0] take_eff;
   logic [N:0]    sum;
   logic          retire;
   logic          acc;
   logic [1:0]    rem;

   always_comb begin
      case (cnt)
         ONE:     avail = AW'(PKT) - AW'(ptr);
         TWO:     avail = AW'(2 * PKT) - AW'(ptr);
         default: avail = '0;
      endcase
   end

   assign out_cnt  = CW'(min_cnt(32'(avail), K));
   assign take_eff = (out_take > out_cnt) ? out_cnt : out_take;
   assign sum      = {1'b0, ptr} + (N+1)'(take_eff);
   // Carry out of the offset means the head packet has been fully consumed.
   assign retire   = sum[N];
   assign in_ready = ~flush & ((cnt != TWO) | retire);
   assign acc      = in_valid & in_ready;
   assign rem      = cnt - {1'b0, retire};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= EMPTY;
         ptr  <= '0;
      end else if (flush) begin
         cnt <= EMPTY;
         ptr <= '0;
      end else begin
         if (retire) ent0 <= ent1;
         // A packet landing in an empty (or emptying) buffer becomes the head.
         if (acc) begin
            if (rem == 2'd0) ent0 <= in_data;
            else             ent1 <= in_data;
         end
         cnt <= cnt_t'(rem + {1'b0, acc});
         ptr <= (acc && rem == 2'd0) ? in_start : sum[N-1:0];
      end
   end

   gs232c_win_extract #(
      .N  (N),
      .K  (K),
      .W  (W),
      .CW (CW)
   ) u_win (
      .win_in ( 
         {ent1, ent0}),
      .ptr    (ptr),
      .cnt    (out_cnt),
      .win    (out_data)
   );

endmodule
